// File: rtl/wb_write_arbiter_pkg.sv
// Shared definitions for the GRF write-port arbiter: default widths, the
// zero-register encoding and the queued-entry payload {valid, a3, wd, pc}.
package wb_write_arbiter_pkg;

  localparam int unsigned WB_DEPTH = 4;   // MDU result FIFO entries
  localparam int unsigned WB_AW    = 5;   // register address width
  localparam int unsigned WB_DW    = 32;  // data / PC width

  // $0 is hard-wired; writes to it are discarded
  localparam logic [WB_AW-1:0] REG_ZERO = '0;

  // One register-file write: a queued MDU result or the grf_* output register
  typedef struct packed {
    logic             valid;
    logic [WB_AW-1:0] a3;
    logic [WB_DW-1:0] wd;
    logic [WB_DW-1:0] pc;
  } wb_entry_t;

endpackage

// File: rtl/wb_write_arbiter_fifo.sv
// MDU result FIFO with per-entry valid bits.
// Ports: enq/deq handshake (caller guarantees enq only when ready_o, deq only
// when nonempty_c_o), squash_i/squash_a3_i invalidate queued entries for a
// register, rd_a1_i/rd_a2_i produce combinational pending-write hits, head_c_o
// exposes the oldest entry, ready_o is registered (count < DEPTH).
module wb_write_arbiter_fifo
  import wb_write_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = WB_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enq_i,
  input  logic [WB_AW-1:0] enq_a3_i,
  input  logic [WB_DW-1:0] enq_wd_i,
  input  logic [WB_DW-1:0] enq_pc_i,
  input  logic             deq_i,
  input  logic             squash_i,
  input  logic [WB_AW-1:0] squash_a3_i,
  input  logic [WB_AW-1:0] rd_a1_i,
  input  logic [WB_AW-1:0] rd_a2_i,
  output logic             ready_o,
  output logic             nonempty_c_o,
  output wb_entry_t        head_c_o,
  output logic             hit1_c_o,
  output logic             hit2_c_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  wb_entry_t     mem_q [DEPTH];
  wb_entry_t     mem_d [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ready_q, ready_d;

  // Next-state: squash first, then pop, then push so a result accepted in the
  // same edge as a pipe write to its register stays valid (it is newer).
  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (squash_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (mem_q[PW'(i)].a3 == squash_a3_i) mem_d[PW'(i)].valid = 1'b0;
      end
    end
    if (deq_i) begin
      mem_d[rptr_q].valid = 1'b0;
      rptr_d              = rptr_q + PW'(1);
    end
    if (enq_i) begin
      mem_d[wptr_q].valid = 1'b1;
      mem_d[wptr_q].a3    = enq_a3_i;
      mem_d[wptr_q].wd    = enq_wd_i;
      mem_d[wptr_q].pc    = enq_pc_i;
      wptr_d              = wptr_q + PW'(1);
    end
    cnt_d   = cnt_q + CW'(enq_i) - CW'(deq_i);
    ready_d = (cnt_d < CW'(DEPTH));
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[PW'(i)] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[PW'(i)] <= mem_d[PW'(i)];
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  // Popped entries have their valid cleared, so the write now sitting in the
  // grf_* register never shows up as a pending hit.
  always_comb begin
    hit1_c_o = 1'b0;
    hit2_c_o = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (mem_q[PW'(i)].valid && (mem_q[PW'(i)].a3 == rd_a1_i) && (rd_a1_i != REG_ZERO))
        hit1_c_o = 1'b1;
      if (mem_q[PW'(i)].valid && (mem_q[PW'(i)].a3 == rd_a2_i) && (rd_a2_i != REG_ZERO))
        hit2_c_o = 1'b1;
    end
  end

  assign ready_o      = ready_q;
  assign nonempty_c_o = (cnt_q != '0);
  assign head_c_o     = mem_q[rptr_q];

endmodule

// File: rtl/wb_write_arbiter.sv
// GRF write-port arbiter: W-stage writes always take the slot; MDU results
// are queued and drained into idle slots.
// Ports: clk/reset (async, active-low), pipe_* (W-stage write), mdu_* (MDU
// result handshake, mdu_ready registered), rd_a1/rd_a2 -> pend_hit1/2
// (combinational hazard lookups), grf_* (registered GRF write port).
module wb_write_arbiter
  import wb_write_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = WB_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pipe_we,
  input  logic [WB_AW-1:0] pipe_a3,
  input  logic [WB_DW-1:0] pipe_wd,
  input  logic [WB_DW-1:0] pipe_pc,
  input  logic             mdu_valid,
  output logic             mdu_ready,
  input  logic [WB_AW-1:0] mdu_a3,
  input  logic [WB_DW-1:0] mdu_wd,
  input  logic [WB_DW-1:0] mdu_pc,
  input  logic [WB_AW-1:0] rd_a1,
  input  logic [WB_AW-1:0] rd_a2,
  output logic             pend_hit1,
  output logic             pend_hit2,
  output logic             grf_we,
  output logic [WB_AW-1:0] grf_a3,
  output logic [WB_DW-1:0] grf_wd,
  output logic [WB_DW-1:0] grf_pc
);

  logic      pipe_eff;
  logic      enq;
  logic      deq;
  logic      drain_wr;
  logic      nonempty;
  wb_entry_t head;
  wb_entry_t grf_q, grf_d;

  assign pipe_eff = pipe_we && (pipe_a3 != REG_ZERO);
  // Results for $0 complete the handshake but are never queued
  assign enq      = mdu_valid && mdu_ready && (mdu_a3 != REG_ZERO);
  // A squashed head pops without needing the write slot
  assign deq      = nonempty && (!head.valid || !pipe_eff);
  assign drain_wr = nonempty && head.valid && !pipe_eff;

  wb_write_arbiter_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst_n        (reset),
    .enq_i        (enq),
    .enq_a3_i     (mdu_a3),
    .enq_wd_i     (mdu_wd),
    .enq_pc_i     (mdu_pc),
    .deq_i        (deq),
    .squash_i     (pipe_eff),
    .squash_a3_i  (pipe_a3),
    .rd_a1_i      (rd_a1),
    .rd_a2_i      (rd_a2),
    .ready_o      (mdu_ready),
    .nonempty_c_o (nonempty),
    .head_c_o     (head),
    .hit1_c_o     (pend_hit1),
    .hit2_c_o     (pend_hit2)
  );

  // Slot arbitration; idle slots keep the last address/data/PC
  always_comb begin
    grf_d       = grf_q;
    grf_d.valid = 1'b0;
    if (pipe_eff) begin
      grf_d.valid = 1'b1;
      grf_d.a3    = pipe_a3;
      grf_d.wd    = pipe_wd;
      grf_d.pc    = pipe_pc;
    end else if (drain_wr) begin
      grf_d = head;
    end
  end

  // GRF output register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) grf_q <= '0;
    else        grf_q <= grf_d;
  end

  assign grf_we = grf_q.valid;
  assign grf_a3 = grf_q.a3;
  assign grf_wd = grf_q.wd;
  assign grf_pc = grf_q.pc;

endmodule
